// File: rtl/icdf_pkg.sv
// Shared widths, default latencies, FSM states and the segment-address decode
// for the ICDF issue controller.
package icdf_pkg;

   localparam int URNG_W       = 32;
   localparam int ADDR_W       = 7;
   localparam int MASK_W       = 15;
   localparam int RES_W        = 16;
   localparam int PIPE_LAT_DEF = 6;
   localparam int ROM_LAT_DEF  = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // {lz, sub}: lz = leading zeros (capped at 15), sub = three bits under the leading one
   function automatic logic [ADDR_W-1:0] seg_addr(input logic [15:0] field);
      logic [3:0]  lz;
      logic [31:0] sh;
      lz = 4'd15;
      for (int i = 0; i < 16; i++) begin
         if (field[i]) lz = 4'(15 - i);
      end
      sh = {16'h0000, field} << (32'(lz) + 32'd1);
      return {lz, sh[15:13]};
   endfunction

endpackage

// File: rtl/icdf_out_fifo.sv
// Synchronous result FIFO with occupancy count; writes when full and reads when
// empty are ignored.
module icdf_out_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/icdf_issue_ctrl.sv
// ICDF issue/flow-control sequencer: decodes uniform samples, tracks in-flight
// tokens and captures sign-corrected results under FIFO credit.
// Optional statistics outputs are enabled by defining ICDF_CTRL_STATS_EN.
module icdf_issue_ctrl
   import icdf_pkg::*;
#(
   parameter int PIPE_LAT   = PIPE_LAT_DEF,
   parameter int ROM_LAT    = ROM_LAT_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              urng_valid,
   input  logic [URNG_W-1:0] urng_data,
   output logic              urng_ready,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   output logic [MASK_W-1:0] masked_out,
   output logic              dp_en,
   input  logic [RES_W-1:0]  dp_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  out_data,
   output state_t            dbg_state
`ifdef ICDF_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_samples,
   output logic [31:0]       stat_stalls
`endif
);

   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ICNT_W = $clog2(PIPE_LAT + 1);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; ready never depends on valid, and valid is not withdrawn by this block.
   state_t              state_q, state_d;
   logic [PIPE_LAT-1:0] tok_q, sgn_q;
   logic [MASK_W-1:0]   mask_q [ROM_LAT];
   logic [ICNT_W-1:0]   inflight;
   logic [FCNT_W-1:0]   fifo_count;
   logic [RES_W:0]      head;
   logic                fifo_empty, credit, issue;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + ICNT_W'(tok_q[i]);
   end

   // Counting tokens as well as stored results guarantees every capture has a slot
   assign credit = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);

   always_comb begin
      state_d    = state_q;
      urng_ready = 1'b0;
      dp_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (urng_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            dp_en      = 1'b1;
            urng_ready = credit;
            if (!urng_valid) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            dp_en = 1'b1;
            if (urng_valid)          state_d = ST_RUN;
            else if (inflight == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign dbg_state = state_q;
   assign issue     = urng_valid && urng_ready;
   assign rom_en    = issue;
   assign rom_addr  = issue ? seg_addr(urng_data[30:15]) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tok_q <= '0;
         sgn_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) mask_q[i] <= '0;
      end else begin
         tok_q     <= {tok_q[PIPE_LAT-2:0], issue};
         sgn_q     <= {sgn_q[PIPE_LAT-2:0], issue && urng_data[31]};
         mask_q[0] <= issue ? urng_data[MASK_W-1:0] : '0;
         for (int i = 1; i < ROM_LAT; i++) mask_q[i] <= mask_q[i-1];
      end
   end

   assign masked_out = mask_q[ROM_LAT-1];

   icdf_out_fifo #(
      .W     (RES_W + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tok_q[PIPE_LAT-1]),
      .wdata ({sgn_q[PIPE_LAT-1], dp_result}),
      .pop   (out_valid && out_ready),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty)
   );

   assign out_valid = !fifo_empty;

   // Negating the most negative result would wrap, so it saturates to the maximum
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         if (!head[RES_W])
            out_data = head[RES_W-1:0];
         else if (head[RES_W-1:0] == {1'b1, {(RES_W-1){1'b0}}})
            out_data = {1'b0, {(RES_W-1){1'b1}}};
         else
            out_data = -head[RES_W-1:0];
      end
   end

`ifdef ICDF_CTRL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_samples <= '0;
         stat_stalls  <= '0;
      end else begin
         if (issue) stat_samples <= stat_samples + 32'd1;
         if (state_q == ST_RUN && urng_valid && !urng_ready && stat_stalls != '1)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icdf_issue_ctrl.sv
// Randomised and directed bench for icdf_issue_ctrl with a queue-based scoreboard.
module tb_icdf_issue_ctrl;
   import icdf_pkg::*;

   localparam int PIPE_LAT   = 6;
   localparam int ROM_LAT    = 1;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        urng_valid;
   logic [31:0] urng_data;
   logic        urng_ready;
   logic [6:0]  rom_addr;
   logic        rom_en;
   logic [14:0] masked_out;
   logic        dp_en;
   logic [15:0] dp_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   state_t      dbg_state;
`ifdef ICDF_CTRL_STATS_EN
   logic [31:0] stat_samples;
   logic [31:0] stat_stalls;
`endif

   icdf_issue_ctrl #(
      .PIPE_LAT   (PIPE_LAT),
      .ROM_LAT    (ROM_LAT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .urng_valid (urng_valid),
      .urng_data  (urng_data),
      .urng_ready (urng_ready),
      .rom_addr   (rom_addr),
      .rom_en     (rom_en),
      .masked_out (masked_out),
      .dp_en      (dp_en),
      .dp_result  (dp_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .dbg_state  (dbg_state)
`ifdef ICDF_CTRL_STATS_EN
      ,
      .stat_samples (stat_samples),
      .stat_stalls  (stat_stalls)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [15:0] exp_q[$];
   int          sched_cyc[$];
   logic [15:0] sched_val[$];
   int          mchk_cyc[$];
   logic [14:0] mchk_val[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          n_issue = 0;
   int          iss_since_rst = 0;
   logic        dp_fixed_en = 1'b0;
   logic [15:0] dp_fixed = 16'h0000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference decode: position of the highest set bit found arithmetically
   function automatic logic [6:0] ref_addr(input logic [15:0] f);
      int fi, v, p, lz, sub;
      fi = int'(f);
      v  = fi;
      p  = -1;
      while (v != 0) begin
         v = v >> 1;
         p++;
      end
      if (p < 0) begin
         lz  = 15;
         sub = 0;
      end else begin
         lz  = 15 - p;
         sub = (p >= 3) ? ((fi >> (p - 3)) & 7) : ((fi << (3 - p)) & 7);
      end
      return 7'(lz * 8 + sub);
   endfunction

   function automatic logic [15:0] ref_out(input logic s, input logic [15:0] d);
      int v;
      v = int'($signed(d));
      if (s) v = -v;
      if (v > 32767) v = 32767;
      return 16'(v);
   endfunction

   // ---------------- monitor / datapath model ----------------
   initial begin
      logic [15:0] v;
      dp_result = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
               dp_result = sched_val.pop_front();
               void'(sched_cyc.pop_front());
            end else begin
               dp_result = 16'($urandom);
            end
            if (mchk_cyc.size() > 0 && mchk_cyc[0] == cyc) begin
               check("masked_out", 32'(masked_out), 32'(mchk_val.pop_front()));
               void'(mchk_cyc.pop_front());
            end
            if (urng_valid && urng_ready) begin
               v = dp_fixed_en ? dp_fixed : 16'($urandom);
               check("rom_addr", 32'(rom_addr), 32'(ref_addr(urng_data[30:15])));
               check("rom_en", 32'(rom_en), 32'd1);
               mchk_cyc.push_back(cyc + ROM_LAT);
               mchk_val.push_back(urng_data[14:0]);
               sched_cyc.push_back(cyc + PIPE_LAT);
               sched_val.push_back(v);
               exp_q.push_back(ref_out(urng_data[31], v));
               n_issue++;
               iss_since_rst++;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL out_unexpected: got %h expected no output (cycle %0d)", out_data, cyc);
               end else begin
                  check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_one(input logic [31:0] d, output int icyc, output logic [6:0] addr_seen);
      urng_data  = d;
      urng_valid = 1'b1;
      icyc       = -1;
      addr_seen  = '0;
      for (int k = 0; k < 40 && icyc < 0; k++) begin
         @(negedge clk);
         if (urng_ready) begin
            icyc      = cyc;
            addr_seen = rom_addr;
         end
      end
      check("accept_timeout", 32'(icyc >= 0), 32'd1);
      @(posedge clk);
      #1;
      urng_valid = 1'b0;
   endtask

   task automatic rand_data();
      logic [31:0] d;
      d     = $urandom >> $urandom_range(1, 24);
      d[31] = 1'($urandom);
      urng_data = d;
   endtask

   task automatic run_stream(input int n, input int vpct, input int rpct);
      logic acc;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         acc = urng_valid && urng_ready;
         @(posedge clk);
         #1;
         if (acc || !urng_valid) begin
            urng_valid = ($urandom_range(0, 99) < vpct);
            rand_data();
         end
         out_ready = ($urandom_range(0, 99) < rpct);
      end
   endtask

   task automatic wait_empty(input int budget);
      for (int k = 0; k < budget && (exp_q.size() != 0 || dbg_state != ST_IDLE); k++)
         @(negedge clk);
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_urng_ready"}, 32'(urng_ready), 32'd0);
      check({tag, "_rom_en"},     32'(rom_en),     32'd0);
      check({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
      check({tag, "_masked_out"}, 32'(masked_out), 32'd0);
      check({tag, "_dp_en"},      32'(dp_en),      32'd0);
      check({tag, "_out_valid"},  32'(out_valid),  32'd0);
      check({tag, "_out_data"},   32'(out_data),   32'd0);
      check({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          ic, n0;
      logic [6:0]  a;
      logic        drain_ok;

      rst        = 1'b1;
      urng_valid = 1'b0;
      urng_data  = '0;
      out_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // First sample: ready one cycle after valid, top-segment address
      out_ready  = 1'b1;
      urng_data  = 32'h4000_1234;
      urng_valid = 1'b1;
      @(negedge clk);
      check("ready_in_idle", 32'(urng_ready), 32'd0);
      @(negedge clk);
      check("ready_after_start", 32'(urng_ready), 32'd1);
      check("first_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1;
      urng_valid = 1'b0;
      @(negedge clk);
      check("first_masked", 32'(masked_out), 32'h1234);
      wait_empty(100);

      // Negative sample, smallest non-zero field, latency to out_valid
      dp_fixed_en = 1'b1;
      dp_fixed    = 16'h0100;
      send_one(32'h8000_8005, ic, a);
      dp_fixed_en = 1'b0;
      check("neg_rom_addr", 32'(a), 32'h78);
      while (cyc < ic + PIPE_LAT) @(negedge clk);
      check("valid_before_latency", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("valid_at_latency", 32'(out_valid), 32'd1);
      check("neg_out_data", 32'(out_data), 32'hFF00);
      wait_empty(100);

      // Saturation of the most negative result
      dp_fixed_en = 1'b1;
      dp_fixed    = 16'h8000;
      send_one(32'h9234_5678, ic, a);
      dp_fixed_en = 1'b0;
      while (cyc < ic + PIPE_LAT + 1) @(negedge clk);
      check("sat_out_data", 32'(out_data), 32'h7FFF);
      wait_empty(100);

      // Continuous stream, then random valid/ready mix
      run_stream(60, 100, 100);
      run_stream(400, 80, 75);
      urng_valid = 1'b0;
      out_ready  = 1'b1;
      wait_empty(200);

      // Backpressure: exactly FIFO_DEPTH accepted
      out_ready = 1'b0;
      n0        = n_issue;
      rand_data();
      run_stream(30, 100, 0);
      @(negedge clk);
      check("bp_accept_count", 32'(n_issue - n0), 32'(FIFO_DEPTH));
      check("bp_ready_low", 32'(urng_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      urng_valid = 1'b0;
      out_ready  = 1'b1;
      wait_empty(200);

      // Drain: dp_en held until the last token is captured
      run_stream(8, 100, 100);
      urng_valid = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
      drain_ok = 1'b1;
      for (int k = 0; k < 30 && dbg_state == ST_DRAIN; k++) begin
         if (!dp_en) drain_ok = 1'b0;
         @(negedge clk);
      end
      check("drain_dp_en_held", 32'(drain_ok), 32'd1);
      check("drain_to_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("idle_dp_en", 32'(dp_en), 32'd0);
      check("drain_all_captured", 32'(sched_cyc.size()), 32'd0);
      wait_empty(100);

      // Reset asserted while draining
      run_stream(8, 100, 100);
      urng_valid = 1'b0;
      out_ready  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("pre_reset_drain", 32'(dbg_state), 32'(ST_DRAIN));
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      sched_cyc.delete();
      sched_val.delete();
      mchk_cyc.delete();
      mchk_val.delete();
      iss_since_rst = 0;
      @(negedge clk);
      check_reset_values("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Recovery after reset
      run_stream(40, 90, 90);
      urng_valid = 1'b0;
      out_ready  = 1'b1;
      wait_empty(200);
`ifdef ICDF_CTRL_STATS_EN
      check("stat_samples", stat_samples, 32'(iss_since_rst));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
